// File: rtl/grf_scoreboard.sv
// Register file with write-through bypass and per-register outstanding-write scoreboard.
// Optional write trace enabled by defining GRF_TRACE_EN.
module grf_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int CNT_W  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              pc,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [DATA_W-1:0]        wd,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic                     rsv_full,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    output logic [NUM_RD-1:0]        rd_busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [CNT_W-1:0]  r_cnt  [DEPTH];

    logic w_wrValid;
    logic w_rsvValid;

    assign w_wrValid  = we && (wa != '0);
    assign w_rsvValid = rsv_en && (rsv_addr != '0);
    assign rsv_full   = w_rsvValid && (r_cnt[rsv_addr] == CNT_MAX);

    // A saturated reserve is refused outright; a matching writeback only releases.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                r_regs[r] <= '0;
                r_cnt[r]  <= '0;
            end
        end else begin
            if (w_wrValid) begin
                r_regs[wa] <= wd;
            end
            for (int r = 1; r < DEPTH; r++) begin
                logic incR;
                logic decR;
                incR = w_rsvValid && (rsv_addr == ADDR_W'(r)) && (r_cnt[r] != CNT_MAX);
                decR = w_wrValid && (wa == ADDR_W'(r)) && (r_cnt[r] != '0);
                if (incR && !decR) begin
                    r_cnt[r] <= r_cnt[r] + CNT_W'(1);
                end else if (decR && !incR) begin
                    r_cnt[r] <= r_cnt[r] - CNT_W'(1);
                end
            end
        end
    end

    // Busy uses the post-writeback count so it drops together with bypassed data.
    always_comb begin
        rd      = '0;
        rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            logic [ADDR_W-1:0] idx;
            logic              hit;
            logic [CNT_W-1:0]  cntEff;
            idx    = ra[k*ADDR_W +: ADDR_W];
            hit    = w_wrValid && (wa == idx);
            cntEff = r_cnt[idx] - CNT_W'(hit && (r_cnt[idx] != '0));
            if (idx == '0) begin
                rd[k*DATA_W +: DATA_W] = '0;
            end else if (hit) begin
                rd[k*DATA_W +: DATA_W] = wd;
            end else begin
                rd[k*DATA_W +: DATA_W] = r_regs[idx];
            end
            rd_busy[k] = (idx != '0) && (cntEff != '0);
        end
    end

`ifdef GRF_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset && w_wrValid) begin
            $display("@%h: $%d <= %h", pc, wa, wd);
        end
    end
`else
    logic w_unusedPc;
    assign w_unusedPc = ^pc;
`endif

endmodule

// File: tb/tb_grf_scoreboard.sv
// Directed self-checking bench for grf_scoreboard (default parameters, two read ports).
module tb_grf_scoreboard;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;
    localparam int CNT_W  = 2;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [31:0]              pc;
    logic                     we;
    logic [ADDR_W-1:0]        wa;
    logic [DATA_W-1:0]        wd;
    logic                     rsv_en;
    logic [ADDR_W-1:0]        rsv_addr;
    logic                     rsv_full;
    logic [NUM_RD*ADDR_W-1:0] ra;
    logic [NUM_RD*DATA_W-1:0] rd;
    logic [NUM_RD-1:0]        rd_busy;

    int asserts = 0;
    int fails   = 0;

    grf_scoreboard #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .pc(pc),
        .we(we), .wa(wa), .wd(wd),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_full(rsv_full),
        .ra(ra), .rd(rd), .rd_busy(rd_busy)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs change 1ns after it and outputs are sampled 2ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; pc = '0; we = 1'b0; wa = '0; wd = '0;
        rsv_en = 1'b0; rsv_addr = '0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ra = {5'd31, 5'd1};
        settle();
        asserts++;
        if (rd !== 64'h0) begin
            fails++; $display("[TB] FAIL reset_rd: got %h expected %h", rd, 64'h0);
        end
        asserts++;
        if (rd_busy !== 2'b00) begin
            fails++; $display("[TB] FAIL reset_busy: got %b expected %b", rd_busy, 2'b00);
        end
        rsv_en = 1'b1; rsv_addr = 5'd31;
        settle();
        asserts++;
        if (rsv_full !== 1'b0) begin
            fails++; $display("[TB] FAIL reset_full: got %b expected %b", rsv_full, 1'b0);
        end
        idle();
        tick();
    endtask

    task automatic test_bypass();
        we = 1'b1; wa = 5'd8; wd = 32'hDEADBEEF; ra = {5'd8, 5'd8};
        settle();
        asserts++;
        if (rd !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
            fails++; $display("[TB] FAIL bypass_rd: got %h expected %h", rd, {32'hDEADBEEF, 32'hDEADBEEF});
        end
        asserts++;
        if (rd_busy !== 2'b00) begin
            fails++; $display("[TB] FAIL bypass_busy: got %b expected %b", rd_busy, 2'b00);
        end
        tick();
        idle();
        ra = {5'd1, 5'd8};
        settle();
        asserts++;
        if (rd !== {32'h0, 32'hDEADBEEF}) begin
            fails++; $display("[TB] FAIL stored_rd: got %h expected %h", rd, {32'h0, 32'hDEADBEEF});
        end
    endtask

    task automatic test_reserve_full();
        logic [2:0] expFull;
        logic [2:0] expBusy;
        expFull = 3'b000;
        expBusy = 3'b110;
        idle();
        ra = {5'd5, 5'd5};
        for (int i = 0; i < 3; i++) begin
            rsv_en = 1'b1; rsv_addr = 5'd5;
            settle();
            asserts++;
            if (rsv_full !== expFull[i]) begin
                fails++; $display("[TB] FAIL rsv_full_%0d: got %b expected %b", i, rsv_full, expFull[i]);
            end
            asserts++;
            if (rd_busy[0] !== expBusy[i]) begin
                fails++; $display("[TB] FAIL rsv_busy_%0d: got %b expected %b", i, rd_busy[0], expBusy[i]);
            end
            tick();
        end
        settle();
        asserts++;
        if (rsv_full !== 1'b1) begin
            fails++; $display("[TB] FAIL rsv_saturated: got %b expected %b", rsv_full, 1'b1);
        end
        tick();
        // Refusal must hold even with a same-cycle writeback; count goes 3 -> 2.
        we = 1'b1; wa = 5'd5; wd = 32'h0000_0051;
        settle();
        asserts++;
        if (rsv_full !== 1'b1) begin
            fails++; $display("[TB] FAIL rsv_full_with_wb: got %b expected %b", rsv_full, 1'b1);
        end
        asserts++;
        if (rd_busy !== 2'b11) begin
            fails++; $display("[TB] FAIL busy_wb1: got %b expected %b", rd_busy, 2'b11);
        end
        tick();
        rsv_en = 1'b0; wd = 32'h0000_0052;
        settle();
        asserts++;
        if (rd_busy !== 2'b11) begin
            fails++; $display("[TB] FAIL busy_wb2: got %b expected %b", rd_busy, 2'b11);
        end
        tick();
        wd = 32'h0000_0053;
        settle();
        asserts++;
        if (rd_busy !== 2'b00) begin
            fails++; $display("[TB] FAIL busy_wb3: got %b expected %b", rd_busy, 2'b00);
        end
        asserts++;
        if (rd[31:0] !== 32'h0000_0053) begin
            fails++; $display("[TB] FAIL rd_wb3: got %h expected %h", rd[31:0], 32'h0000_0053);
        end
        tick();
        idle();
        settle();
        asserts++;
        if (rd_busy !== 2'b00) begin
            fails++; $display("[TB] FAIL busy_after_release: got %b expected %b", rd_busy, 2'b00);
        end
    endtask

    task automatic test_same_cycle();
        idle();
        ra = {5'd1, 5'd9};
        rsv_en = 1'b1; rsv_addr = 5'd9;
        tick();
        we = 1'b1; wa = 5'd9; wd = 32'h0000_1234;
        settle();
        asserts++;
        if (rd_busy[0] !== 1'b0) begin
            fails++; $display("[TB] FAIL same_busy_now: got %b expected %b", rd_busy[0], 1'b0);
        end
        asserts++;
        if (rd[31:0] !== 32'h0000_1234) begin
            fails++; $display("[TB] FAIL same_rd_now: got %h expected %h", rd[31:0], 32'h0000_1234);
        end
        tick();
        idle();
        settle();
        asserts++;
        if (rd_busy[0] !== 1'b1) begin
            fails++; $display("[TB] FAIL same_busy_next: got %b expected %b", rd_busy[0], 1'b1);
        end
        asserts++;
        if (rd[31:0] !== 32'h0000_1234) begin
            fails++; $display("[TB] FAIL same_rd_next: got %h expected %h", rd[31:0], 32'h0000_1234);
        end
        we = 1'b1; wa = 5'd9; wd = 32'h0000_5678;
        tick();
        idle();
    endtask

    task automatic test_reg_zero();
        idle();
        pc = 32'h0000_2000;
        we = 1'b1; wa = 5'd0; wd = 32'h5;
        rsv_en = 1'b1; rsv_addr = 5'd0;
        ra = {5'd0, 5'd0};
        settle();
        asserts++;
        if (rd !== 64'h0 || rd_busy !== 2'b00 || rsv_full !== 1'b0) begin
            fails++; $display("[TB] FAIL zero_now: got rd=%h busy=%b full=%b expected 0 00 0", rd, rd_busy, rsv_full);
        end
        for (int i = 0; i < 4; i++) tick();
        idle();
        settle();
        asserts++;
        if (rd !== 64'h0 || rd_busy !== 2'b00) begin
            fails++; $display("[TB] FAIL zero_after: got rd=%h busy=%b expected 0 00", rd, rd_busy);
        end
    endtask

    task automatic test_reset_mid();
        idle();
        ra = {5'd8, 5'd4};
        we = 1'b1; wa = 5'd4; wd = 32'h0000_00AA;
        tick();
        idle();
        settle();
        asserts++;
        if (rd_busy[0] !== 1'b0 || rd[31:0] !== 32'h0000_00AA) begin
            fails++; $display("[TB] FAIL unreserved_wb: got busy=%b rd=%h expected 0 000000aa", rd_busy[0], rd[31:0]);
        end
        rsv_en = 1'b1; rsv_addr = 5'd4;
        tick();
        tick();
        idle();
        settle();
        asserts++;
        if (rd_busy[0] !== 1'b1) begin
            fails++; $display("[TB] FAIL mid_busy: got %b expected %b", rd_busy[0], 1'b1);
        end
        reset = 1'b1;
        we = 1'b1; wa = 5'd4; wd = 32'h0000_00BB;
        rsv_en = 1'b1; rsv_addr = 5'd4;
        tick();
        idle();
        settle();
        asserts++;
        if (rd !== 64'h0 || rd_busy !== 2'b00) begin
            fails++; $display("[TB] FAIL reset_mid: got rd=%h busy=%b expected 0 00", rd, rd_busy);
        end
    endtask

    initial begin
        idle();
        ra = '0;
        tick();
        test_reset();
        test_bypass();
        test_reserve_full();
        test_same_cycle();
        test_reg_zero();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
